// File: rtl/ser_pkg.sv
// ser_pkg: definitions shared by the bit_serializer block.
//   ser_state_t   - serializer FSM state encoding (IDLE, SHIFT, PARITY)
//   SER_MAX_WIDTH - largest supported parallel word width
//   ser_cnt_width - bit counter width needed for a given word width
package ser_pkg;

    localparam int unsigned SER_MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser_state_t;

    function automatic int unsigned ser_cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial stage feeding the seq_detector x input.
// Accepts WIDTH-bit words on a valid/ready handshake and emits one bit per
// clock on a registered x/x_valid pair. Back-to-back words need no idle gap.
// Optional even-parity bit after each word when SER_PARITY_EN is defined.
//
// Parameters:
//   WIDTH     - bits per parallel word (2..32)
//   LSB_FIRST - 0: bit WIDTH-1 leaves first, 1: bit 0 leaves first
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous active-low reset
//   din       - parallel word
//   din_valid - din holds a word to send
//   din_ready - block accepts din this cycle
//   x         - serial bit (0 whenever x_valid is 0)
//   x_valid   - x carries a live data (or parity) bit
//   busy      - a word or parity bit is in flight (state != IDLE)
module bit_serializer
    import ser_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy
);

    localparam int unsigned CNT_W = ser_cnt_width(WIDTH);

    ser_state_t       state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             x_q, x_d;
    logic             xv_q, xv_d;
`ifdef SER_PARITY_EN
    logic             par_q, par_d;
`endif

    logic             ready_int;
    logic             accept;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] load_sh;
    logic [WIDTH-1:0] adv_sh;

    // The first bit goes straight to x on the accept edge; the shift register
    // holds only the remaining bits, pre-shifted so the next bit sits at the
    // outgoing end.
    assign first_bit = LSB_FIRST ? din[0]  : din[WIDTH-1];
    assign load_sh   = LSB_FIRST ? (din >> 1) : (din << 1);
    assign next_bit  = LSB_FIRST ? sh_q[0] : sh_q[WIDTH-1];
    assign adv_sh    = LSB_FIRST ? (sh_q >> 1) : (sh_q << 1);

    // Ready in IDLE and in the final cycle of a word, so a held din_valid
    // reloads on the same edge the last bit is replaced.
    always_comb begin
        ready_int = 1'b0;
        case (state_q)
            IDLE:    ready_int = 1'b1;
`ifdef SER_PARITY_EN
            PARITY:  ready_int = 1'b1;
`else
            SHIFT:   ready_int = (cnt_q == '0);
`endif
            default: ready_int = 1'b0;
        endcase
    end

    assign accept = din_valid && ready_int;

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        x_d     = 1'b0;
        xv_d    = 1'b0;
`ifdef SER_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    sh_d    = load_sh;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    x_d     = first_bit;
                    xv_d    = 1'b1;
`ifdef SER_PARITY_EN
                    par_d   = ^din;
`endif
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    sh_d  = adv_sh;
                    cnt_d = cnt_q - 1'b1;
                    x_d   = next_bit;
                    xv_d  = 1'b1;
                end else begin
`ifdef SER_PARITY_EN
                    state_d = PARITY;
                    x_d     = par_q;
                    xv_d    = 1'b1;
`else
                    if (accept) begin
                        sh_d  = load_sh;
                        cnt_d = CNT_W'(WIDTH - 1);
                        x_d   = first_bit;
                        xv_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
`endif
                end
            end
`ifdef SER_PARITY_EN
            PARITY: begin
                if (accept) begin
                    state_d = SHIFT;
                    sh_d    = load_sh;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    x_d     = first_bit;
                    xv_d    = 1'b1;
                    par_d   = ^din;
                end else begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            x_q     <= 1'b0;
            xv_q    <= 1'b0;
`ifdef SER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            xv_q    <= xv_d;
`ifdef SER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign din_ready = ready_int;
    assign x         = x_q;
    assign x_valid   = xv_q;
    assign busy      = (state_q != IDLE);

endmodule
